// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch (I) and
// load/store (D) ports, one transaction at a time. Define MEM_ARB_RR_EN for round-robin on contention.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wmask,
   output logic              d_ready,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic              r_mem_en;
   logic [ADDR_W-3:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wmask;
   logic [31:0]       r_i_rdata;
   logic [31:0]       r_d_rdata;
   logic              w_any_req;
   logic              w_grant_d;
   logic              w_take;
   logic              w_resp;
   logic              w_unused_addr_bits;

   assign w_any_req          = i_req | d_req;
   assign w_unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
   // On contention the port that did not win last time gets the grant.
   assign w_grant_d = d_req & (~i_req | ~r_owner);
`else
   assign w_grant_d = d_req;
`endif

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no inferred latch).
      w_state_nxt = r_state;
      w_take      = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_RESP: begin
            if (w_any_req) begin
               w_state_nxt = ST_ACCESS;
               w_take      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: w_state_nxt = ST_RESP;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_owner   <= 1'b0;
         r_mem_en  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
         r_state  <= w_state_nxt;
         r_mem_en <= w_take;
         if (w_take) begin
            r_owner <= w_grant_d;
            if (w_grant_d) begin
               r_addr  <= d_addr[ADDR_W-1:2];
               r_wdata <= d_wdata;
               r_wmask <= d_wmask;
            end else begin
               r_addr  <= i_addr[ADDR_W-1:2];
               r_wdata <= '0;
               r_wmask <= '0;
            end
         end
         // Keep the last delivered word so rdata holds between ready pulses.
         if (r_state == ST_RESP) begin
            if (r_owner) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
         end
      end
   end

   assign w_resp    = (r_state == ST_RESP);
   assign i_ready   = w_resp & ~r_owner;
   assign d_ready   = w_resp & r_owner;
   assign i_rdata   = i_ready ? mem_rdata : r_i_rdata;
   assign d_rdata   = d_ready ? mem_rdata : r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wmask = r_wmask;
   assign busy      = (r_state != ST_IDLE);
   assign owner     = r_owner;

endmodule
